// File: rtl/pipe_stage_reg_if.sv
// Handshake/payload bundle between two pipeline stages plus the stage register's debug counters.
interface pipe_stage_reg_if #(
   parameter int unsigned DATA_W  = 64,
   parameter int unsigned STALL_W = 6,
   parameter int unsigned CNT_W   = 16
);
   logic [STALL_W-1:0] stall;
   logic               flush;
   logic               in_valid;
   logic [DATA_W-1:0]  in_data;
   logic               out_valid;
   logic [DATA_W-1:0]  out_data;
   logic [CNT_W-1:0]   bubble_cnt;
   logic [CNT_W-1:0]   flush_cnt;
   logic [CNT_W-1:0]   hold_run;
   logic               stall_timeout;

   modport master (
      output stall, flush, in_valid, in_data,
      input  out_valid, out_data, bubble_cnt, flush_cnt, hold_run, stall_timeout
   );

   modport slave (
      input  stall, flush, in_valid, in_data,
      output out_valid, out_data, bubble_cnt, flush_cnt, hold_run, stall_timeout
   );
endinterface

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with hold, bubble, flush and payload normalisation,
// plus saturating debug counters and a sticky stall-timeout flag.
module pipe_stage_reg #(
   parameter int unsigned     DATA_W  = 64,
   parameter int unsigned     STALL_W = 6,
   parameter int unsigned     STAGE   = 1,
   parameter logic [DATA_W-1:0] BUBBLE = '0,
   parameter int unsigned     CNT_W   = 16,
   parameter int unsigned     TIMEOUT = 1024
) (
   input logic            clk,
   input logic            reset,
   pipe_stage_reg_if.slave bus
);
   localparam logic [CNT_W-1:0] CNT_MAX     = '1;
   localparam logic [CNT_W-1:0] TIMEOUT_PRE = CNT_W'(TIMEOUT - 1);

   logic              us;
   logic              ds;
   logic              valid_q;
   logic [DATA_W-1:0] data_q;
   logic [CNT_W-1:0]  bubble_cnt_q;
   logic [CNT_W-1:0]  flush_cnt_q;
   logic [CNT_W-1:0]  hold_run_q;
   logic              timeout_q;

   assign us = bus.stall[STAGE];

   // The last stage has no downstream stall bit, so it can never be held.
   if (STAGE == STALL_W - 1) begin : g_last
      assign ds = 1'b0;
   end else begin : g_mid
      assign ds = bus.stall[STAGE+1];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q      <= 1'b0;
         data_q       <= BUBBLE;
         bubble_cnt_q <= '0;
         flush_cnt_q  <= '0;
         hold_run_q   <= '0;
         timeout_q    <= 1'b0;
      end else if (bus.flush) begin
         valid_q    <= 1'b0;
         data_q     <= BUBBLE;
         hold_run_q <= '0;
         if (valid_q && (flush_cnt_q != CNT_MAX)) flush_cnt_q <= flush_cnt_q + 1'b1;
      end else if (ds) begin
         if (hold_run_q != CNT_MAX) hold_run_q <= hold_run_q + 1'b1;
         if (hold_run_q == TIMEOUT_PRE) timeout_q <= 1'b1;
      end else if (us) begin
         valid_q    <= 1'b0;
         data_q     <= BUBBLE;
         hold_run_q <= '0;
         if (bubble_cnt_q != CNT_MAX) bubble_cnt_q <= bubble_cnt_q + 1'b1;
      end else begin
         valid_q    <= bus.in_valid;
         data_q     <= bus.in_valid ? bus.in_data : BUBBLE;
         hold_run_q <= '0;
      end
   end

   assign bus.out_valid     = valid_q;
   assign bus.out_data      = data_q;
   assign bus.bubble_cnt    = bubble_cnt_q;
   assign bus.flush_cnt     = flush_cnt_q;
   assign bus.hold_run      = hold_run_q;
   assign bus.stall_timeout = timeout_q;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench: three stage registers (mid stage, small counters, last stage) share stimulus.
module tb_pipe_stage_reg;
   localparam logic [63:0] TOP_BUBBLE = 64'h0000_0000_0000_0013;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   pipe_stage_reg_if #(.DATA_W(64), .STALL_W(6), .CNT_W(16)) bus_main ();
   pipe_stage_reg_if #(.DATA_W(64), .STALL_W(6), .CNT_W(3))  bus_sat ();
   pipe_stage_reg_if #(.DATA_W(64), .STALL_W(6), .CNT_W(16)) bus_top ();

   pipe_stage_reg #(.DATA_W(64), .STALL_W(6), .STAGE(1), .BUBBLE(64'h0), .CNT_W(16), .TIMEOUT(1024))
      u_main (.clk(clk), .reset(reset), .bus(bus_main));
   pipe_stage_reg #(.DATA_W(64), .STALL_W(6), .STAGE(1), .BUBBLE(64'h0), .CNT_W(3), .TIMEOUT(4))
      u_sat (.clk(clk), .reset(reset), .bus(bus_sat));
   pipe_stage_reg #(.DATA_W(64), .STALL_W(6), .STAGE(5), .BUBBLE(TOP_BUBBLE), .CNT_W(16), .TIMEOUT(1024))
      u_top (.clk(clk), .reset(reset), .bus(bus_top));

   typedef struct {
      logic        v;
      logic [63:0] d;
      int unsigned bc;
      int unsigned fc;
      int unsigned hr;
      logic        to;
   } mstate_t;

   mstate_t m[3];
   mstate_t q_main[$];
   mstate_t q_sat[$];
   mstate_t q_top[$];
   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference behaviour of one stage register for one clock edge.
   function automatic mstate_t model(input mstate_t s, input int stage, input int unsigned cmax,
                                     input int unsigned tmo, input logic [63:0] bub,
                                     input logic rst, input logic fl, input logic [5:0] st,
                                     input logic iv, input logic [63:0] id);
      mstate_t n;
      logic us, ds;
      n  = s;
      us = st[stage];
      ds = 1'b0;
      if (stage < 5) ds = st[stage+1];
      if (rst) begin
         n.v = 1'b0; n.d = bub; n.bc = 0; n.fc = 0; n.hr = 0; n.to = 1'b0;
      end else if (fl) begin
         n.v = 1'b0; n.d = bub; n.hr = 0;
         if (s.v) n.fc = (s.fc + 1 > cmax) ? cmax : s.fc + 1;
      end else if (ds) begin
         n.hr = (s.hr + 1 > cmax) ? cmax : s.hr + 1;
         if (n.hr == tmo && s.hr != tmo) n.to = 1'b1;
      end else if (us) begin
         n.v = 1'b0; n.d = bub; n.hr = 0;
         n.bc = (s.bc + 1 > cmax) ? cmax : s.bc + 1;
      end else begin
         n.v = iv; n.d = iv ? id : bub; n.hr = 0;
      end
      return n;
   endfunction

   function automatic mstate_t snap(input int k);
      mstate_t s;
      case (k)
         0: begin
            s.v = bus_main.out_valid; s.d = bus_main.out_data; s.bc = 32'(bus_main.bubble_cnt);
            s.fc = 32'(bus_main.flush_cnt); s.hr = 32'(bus_main.hold_run); s.to = bus_main.stall_timeout;
         end
         1: begin
            s.v = bus_sat.out_valid; s.d = bus_sat.out_data; s.bc = 32'(bus_sat.bubble_cnt);
            s.fc = 32'(bus_sat.flush_cnt); s.hr = 32'(bus_sat.hold_run); s.to = bus_sat.stall_timeout;
         end
         default: begin
            s.v = bus_top.out_valid; s.d = bus_top.out_data; s.bc = 32'(bus_top.bubble_cnt);
            s.fc = 32'(bus_top.flush_cnt); s.hr = 32'(bus_top.hold_run); s.to = bus_top.stall_timeout;
         end
      endcase
      return s;
   endfunction

   task automatic compare(input string nm, input mstate_t got, input mstate_t exp);
      check($sformatf("%s.out_valid", nm), 64'(got.v), 64'(exp.v));
      check($sformatf("%s.out_data", nm), got.d, exp.d);
      check($sformatf("%s.bubble_cnt", nm), 64'(got.bc), 64'(exp.bc));
      check($sformatf("%s.flush_cnt", nm), 64'(got.fc), 64'(exp.fc));
      check($sformatf("%s.hold_run", nm), 64'(got.hr), 64'(exp.hr));
      check($sformatf("%s.stall_timeout", nm), 64'(got.to), 64'(exp.to));
   endtask

   // Drive one cycle of stimulus, predict all three registers, then score after the edge.
   task automatic cycle(input logic rst, input logic fl, input logic [5:0] st,
                        input logic iv, input logic [63:0] id);
      reset = rst;
      bus_main.stall = st; bus_main.flush = fl; bus_main.in_valid = iv; bus_main.in_data = id;
      bus_sat.stall  = st; bus_sat.flush  = fl; bus_sat.in_valid  = iv; bus_sat.in_data  = id;
      bus_top.stall  = st; bus_top.flush  = fl; bus_top.in_valid  = iv; bus_top.in_data  = id;
      m[0] = model(m[0], 1, 65535, 1024, 64'h0, rst, fl, st, iv, id);
      m[1] = model(m[1], 1, 7, 4, 64'h0, rst, fl, st, iv, id);
      m[2] = model(m[2], 5, 65535, 1024, TOP_BUBBLE, rst, fl, st, iv, id);
      q_main.push_back(m[0]);
      q_sat.push_back(m[1]);
      q_top.push_back(m[2]);
      @(posedge clk);
      #1;
      compare("main", snap(0), q_main.pop_front());
      compare("sat", snap(1), q_sat.pop_front());
      compare("top", snap(2), q_top.pop_front());
   endtask

   function automatic logic [63:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   initial begin
      for (int k = 0; k < 3; k++) m[k] = '{1'b0, 64'h0, 0, 0, 0, 1'b0};
      reset = 1'b1;
      bus_main.stall = '0; bus_main.flush = 1'b0; bus_main.in_valid = 1'b0; bus_main.in_data = '0;
      bus_sat.stall  = '0; bus_sat.flush  = 1'b0; bus_sat.in_valid  = 1'b0; bus_sat.in_data  = '0;
      bus_top.stall  = '0; bus_top.flush  = 1'b0; bus_top.in_valid  = 1'b0; bus_top.in_data  = '0;
      @(negedge clk);

      // Reset then pass-through
      cycle(1'b1, 1'b0, 6'b0, 1'b1, 64'h0000_0040_2002_0001);
      check("rst.main_valid", 64'(bus_main.out_valid), 64'h0);
      check("rst.top_bubble", bus_top.out_data, TOP_BUBBLE);
      cycle(1'b1, 1'b0, 6'b0, 1'b1, 64'h0000_0040_2002_0001);
      cycle(1'b0, 1'b0, 6'b0, 1'b1, 64'h0000_0040_2002_0001);
      check("pass.data", bus_main.out_data, 64'h0000_0040_2002_0001);

      // Bubble then hold the bubble
      cycle(1'b0, 1'b0, 6'b000010, 1'b1, rnd64());
      check("bubble.valid", 64'(bus_main.out_valid), 64'h0);
      check("bubble.cnt", 64'(bus_main.bubble_cnt), 64'd1);
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 1'b0, 6'b000110, 1'b1, rnd64());
         check("hold.run", 64'(bus_main.hold_run), 64'(i + 1));
      end
      check("hold.bubble_cnt", 64'(bus_main.bubble_cnt), 64'd1);

      // Flush priority over stalls, then flush of an empty entry
      cycle(1'b0, 1'b0, 6'b0, 1'b1, 64'h1111_2222_3333_4444);
      cycle(1'b0, 1'b1, 6'b000110, 1'b1, rnd64());
      check("flush.cnt", 64'(bus_main.flush_cnt), 64'd1);
      check("flush.hold_run", 64'(bus_main.hold_run), 64'd0);
      cycle(1'b0, 1'b1, 6'b000110, 1'b1, rnd64());
      check("flush.cnt_again", 64'(bus_main.flush_cnt), 64'd1);

      // Invalid capture must not expose payload
      cycle(1'b0, 1'b0, 6'b0, 1'b0, 64'hDEAD_BEEF_DEAD_BEEF);
      check("inv.data", bus_main.out_data, 64'h0);
      check("inv.top_data", bus_top.out_data, TOP_BUBBLE);

      // Long hold: timeout and hold_run saturation on the small-counter instance
      cycle(1'b0, 1'b0, 6'b0, 1'b1, 64'hCAFE_F00D_0123_4567);
      for (int i = 1; i <= 10; i++) begin
         cycle(1'b0, 1'b0, 6'b000110, 1'b1, rnd64());
         if (i == 3) check("sat.timeout_pre", 64'(bus_sat.stall_timeout), 64'h0);
         if (i == 4) check("sat.timeout_set", 64'(bus_sat.stall_timeout), 64'h1);
      end
      check("sat.hold_run_max", 64'(bus_sat.hold_run), 64'd7);
      check("hold.data_exact", bus_main.out_data, 64'hCAFE_F00D_0123_4567);
      cycle(1'b0, 1'b0, 6'b0, 1'b1, rnd64());
      check("sat.hold_run_clr", 64'(bus_sat.hold_run), 64'd0);
      check("sat.timeout_sticky", 64'(bus_sat.stall_timeout), 64'h1);

      // Bubble counter saturation, then load-use capture
      for (int i = 0; i < 9; i++) cycle(1'b0, 1'b0, 6'b000010, 1'b1, rnd64());
      check("sat.bubble_max", 64'(bus_sat.bubble_cnt), 64'd7);
      cycle(1'b0, 1'b0, 6'b0, 1'b1, 64'h0BAD_C0DE_0000_0001);

      // Last stage: its own stall bit bubbles, no downstream hold
      cycle(1'b0, 1'b0, 6'b100000, 1'b1, rnd64());
      check("top.bubble_valid", 64'(bus_top.out_valid), 64'h0);
      check("top.bubble_cnt", 64'(bus_top.bubble_cnt), 64'd1);

      // Reset together with flush, and reset in the middle of a hold
      cycle(1'b0, 1'b0, 6'b0, 1'b1, rnd64());
      cycle(1'b1, 1'b1, 6'b0, 1'b1, rnd64());
      check("rstflush.fcnt", 64'(bus_main.flush_cnt), 64'd0);
      cycle(1'b0, 1'b0, 6'b0, 1'b1, rnd64());
      cycle(1'b0, 1'b0, 6'b000100, 1'b1, rnd64());
      cycle(1'b1, 1'b0, 6'b000100, 1'b1, rnd64());
      check("rsthold.run", 64'(bus_main.hold_run), 64'd0);

      // Random traffic
      for (int i = 0; i < 200; i++) begin
         cycle(($urandom_range(0, 31) == 0), ($urandom_range(0, 7) == 0), 6'($urandom),
               1'($urandom), rnd64());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
